falafel_rr_input_arbiter: RTL and testbench
===========================================

Name: falafel_rr_input_arbiter

Overview:
Parametrised successor input arbiter for the falafel allocator front end. Accepts NUM_CH generic request channels, each carrying a self-describing request word (opcode + payload). Each channel is buffered in a small per-channel FIFO. Two independent round-robin arbiters drain the buffer heads into the alloc FIFO and the free FIFO. Config-register writes remain outside this block.

Parameters:
NUM_CH, 4, number of request channels (1..16)
BUF_DEPTH, 2, entries per channel buffer (power of two, >=2)
DATA_W, falafel_pkg::DATA_W, request word width
ID_W, falafel_pkg::MSG_ID_SIZE, message id width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
req_val_i  in  NUM_CH  per-channel request valid
req_rdy_o  out  NUM_CH  per-channel ready (buffer not full)
req_data_i  in  NUM_CH x DATA_W  [DATA_W-1:DATA_W-2]=opcode (00 alloc, 01 free, 1x illegal); [DATA_W-3:0]=payload (size or address)
req_id_i  in  NUM_CH x ID_W  message id; captured for alloc requests
alloc_fifo_full_i  in  1  downstream alloc FIFO full
alloc_fifo_write_o  out  1  alloc FIFO write strobe
alloc_fifo_din_size_o  out  DATA_W  zero-extended payload
alloc_fifo_din_id_o  out  ID_W  id of the granted request
free_fifo_full_i  in  1  downstream free FIFO full
free_fifo_write_o  out  1  free FIFO write strobe
free_fifo_din_o  out  DATA_W  zero-extended payload
illegal_o  out  1  one-cycle pulse: an illegal-opcode request was dropped
illegal_ch_o  out  $clog2(NUM_CH) or 1  channel of the dropped request, valid with illegal_o

Behaviour:
- Reset, asynchronous on rst_i high: buffers empty, both RR pointers = 0, all outputs 0, req_rdy_o all 0 while rst_i is high. Once reset is released, req_rdy_o = 1 in the first cycle.
- Accept: req_val_i[c] && req_rdy_o[c] pushes {opcode, payload, id} into buffer c. req_rdy_o[c] = !full[c]; it does not depend on req_val_i.
- Latency: a word accepted at cycle t is eligible for arbitration at t+1. With no contention, write_o is high at t+1.
- Head classification: head of a non-empty buffer with opcode 00 requests alloc; 01 requests free; 1x is popped in the next cycle without a FIFO write and pulses illegal_o/illegal_ch_o. If several channels hold illegal heads, the lowest index is dropped first, one per cycle.
- Alloc arbiter:
  - Active only when !alloc_fifo_full_i.
  - Grants the first requesting channel scanning from alloc_ptr upward, with wrap-around.
  - On grant: write_o = 1, data = head fields, buffer popped at the clock edge, alloc_ptr <= (granted+1) mod NUM_CH.
  - No grant: pointer holds.
- Free arbiter: identical, independent pointer free_ptr, gated by free_fifo_full_i.
- Simultaneous events:
  - Both arbiters may grant in the same cycle, necessarily on different channels.
  - A channel may push and pop in the same cycle, including when full: pop frees the slot, but req_rdy_o is still the registered full flag, so no bypass.
- Output data, strobes and illegal_o are combinational from buffer heads, pointers and full inputs. They are all 0 when no grant or drop occurs.
- Full inputs are sampled each cycle. Full asserted means no write that cycle; heads are held.
- Buffer pointers are $clog2(BUF_DEPTH) bits plus a wrap bit. Payload is zero-extended from DATA_W-2 to DATA_W.
- Ordering: per-channel FIFO order is preserved within each class. Cross-channel order follows RR only.

Optional Feature:
FALAFEL_ARB_STATS_EN
- Defined: adds output grant_cnt_o, NUM_CH x 32. Per-channel saturating counter of alloc+free grants, incrementing by 1 per cycle when either arbiter grants that channel. Cleared on reset.
- Undefined: the port and counters are absent. Behaviour is otherwise identical.

Decomposition:
- falafel_pkg: add req_opcode_e (OP_ALLOC=2'b00, OP_FREE=2'b01), arb_entry_t {opcode, payload, id}, OPCODE_W=2.
- One natural sub-module, falafel_rr_arb: parameter N; inputs req[N], en; outputs gnt one-hot, gnt_idx, with internal pointer. Instantiated twice.
- Per-channel buffers are a generate loop using the existing falafel FIFO primitive.

Test Plan:
- Reset then single alloc: ch0 sends opcode 00, size 0x40, id 3 -> next cycle alloc_fifo_write_o=1, size=0x40, id=3; req_rdy_o[0] stays 1.
- Fairness, NUM_CH=4: all channels hold 3 alloc requests each, full=0 -> grant order 0,1,2,3,0,1,2,3,0,1,2,3; exactly 12 writes.
- Parallel classes: ch1 alloc, ch2 free in the same cycle -> both write strobes high next cycle; alloc_ptr=2, free_ptr=3.
- Backpressure: alloc_fifo_full_i=1 for 5 cycles, ch0 pushes 3 words -> no writes. ch0 accepts 2 words, then req_rdy_o[0]=0. On release, words drain in order.
- Illegal: ch3 sends opcode 10 -> illegal_o=1, illegal_ch_o=3 for one cycle; no FIFO write; buffer 3 empty afterwards.
- Async reset mid-operation: rst_i asserted between clock edges with buffers full -> outputs 0 immediately; after release, buffers empty and pointers 0.

Source files
------------

// File: rtl/falafel_pkg.sv
// Shared types and widths for the falafel allocator front end.
package falafel_pkg;

  localparam int DATA_W      = 32;
  localparam int MSG_ID_SIZE = 8;
  localparam int OPCODE_W    = 2;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ALLOC = 2'b00,
    OP_FREE  = 2'b01
  } req_opcode_e;

  typedef struct packed {
    logic [OPCODE_W-1:0]        opcode;
    logic [DATA_W-OPCODE_W-1:0] payload;
    logic [MSG_ID_SIZE-1:0]     id;
  } arb_entry_t;

  // Any opcode with the top bit set is outside the defined command set.
  function automatic logic is_illegal_op(input logic [OPCODE_W-1:0] op);
    return op[OPCODE_W-1];
  endfunction

endpackage

// File: rtl/falafel_fifo.sv
// Small synchronous FIFO primitive; pointers carry an extra wrap bit.
module falafel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/falafel_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above ptr, with wrap.
module falafel_rr_arb #(
  parameter int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (en && !found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/falafel_rr_input_arbiter.sv
// Per-channel request buffers drained by independent alloc/free RR arbiters.
// Optional per-channel grant counters under FALAFEL_ARB_STATS_EN.
module falafel_rr_input_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = falafel_pkg::DATA_W,
  parameter int ID_W      = falafel_pkg::MSG_ID_SIZE,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CH-1:0]              req_val_i,
  output logic [NUM_CH-1:0]              req_rdy_o,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  req_data_i,
  input  logic [NUM_CH-1:0][ID_W-1:0]    req_id_i,
  input  logic                           alloc_fifo_full_i,
  output logic                           alloc_fifo_write_o,
  output logic [DATA_W-1:0]              alloc_fifo_din_size_o,
  output logic [ID_W-1:0]                alloc_fifo_din_id_o,
  input  logic                           free_fifo_full_i,
  output logic                           free_fifo_write_o,
  output logic [DATA_W-1:0]              free_fifo_din_o,
  output logic                           illegal_o,
  output logic [CH_W-1:0]                illegal_ch_o
`ifdef FALAFEL_ARB_STATS_EN
  ,
  output logic [NUM_CH-1:0][31:0]        grant_cnt_o
`endif
);

  import falafel_pkg::*;

  localparam int ENTRY_W = DATA_W + ID_W;
  localparam int PL_W    = DATA_W - OPCODE_W;

  logic [NUM_CH-1:0]  buf_full;
  logic [NUM_CH-1:0]  buf_empty;
  logic [NUM_CH-1:0]  push;
  logic [NUM_CH-1:0]  pop;
  logic [NUM_CH-1:0]  alloc_req;
  logic [NUM_CH-1:0]  free_req;
  logic [NUM_CH-1:0]  ill_req;
  logic [NUM_CH-1:0]  ill_pop;
  logic [NUM_CH-1:0]  alloc_gnt;
  logic [NUM_CH-1:0]  free_gnt;
  logic [ENTRY_W-1:0] head [NUM_CH];
  logic [CH_W-1:0]    alloc_idx;
  logic [CH_W-1:0]    free_idx;
  logic               ill_found;

  // Handshake: a word moves when req_val_i[c] && req_rdy_o[c] at a rising edge;
  // ready reflects only the registered full flag (no same-cycle pop bypass).
  assign req_rdy_o = ~buf_full & {NUM_CH{~rst_i}};
  assign push      = req_val_i & req_rdy_o;
  assign pop       = alloc_gnt | free_gnt | ill_pop;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [OPCODE_W-1:0] op;

    falafel_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (BUF_DEPTH)
    ) u_buf (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   ({req_data_i[c], req_id_i[c]}),
      .dout  (head[c]),
      .full  (buf_full[c]),
      .empty (buf_empty[c])
    );

    assign op           = head[c][ENTRY_W-1 -: OPCODE_W];
    assign alloc_req[c] = !buf_empty[c] && (op == OP_ALLOC);
    assign free_req[c]  = !buf_empty[c] && (op == OP_FREE);
    assign ill_req[c]   = !buf_empty[c] && is_illegal_op(op);
  end

  falafel_rr_arb #(.N(NUM_CH)) u_alloc_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (alloc_req),
    .en      (!alloc_fifo_full_i),
    .gnt     (alloc_gnt),
    .gnt_idx (alloc_idx)
  );

  falafel_rr_arb #(.N(NUM_CH)) u_free_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (free_req),
    .en      (!free_fifo_full_i),
    .gnt     (free_gnt),
    .gnt_idx (free_idx)
  );

  // Illegal heads are discarded lowest channel first, one per cycle.
  always_comb begin
    ill_pop      = '0;
    illegal_o    = 1'b0;
    illegal_ch_o = '0;
    ill_found    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!ill_found && ill_req[c]) begin
        ill_found    = 1'b1;
        ill_pop[c]   = 1'b1;
        illegal_o    = 1'b1;
        illegal_ch_o = CH_W'(c);
      end
    end
  end

  assign alloc_fifo_write_o    = |alloc_gnt;
  assign alloc_fifo_din_size_o = alloc_fifo_write_o ? DATA_W'(head[alloc_idx][ID_W +: PL_W]) : '0;
  assign alloc_fifo_din_id_o   = alloc_fifo_write_o ? head[alloc_idx][ID_W-1:0] : '0;
  assign free_fifo_write_o     = |free_gnt;
  assign free_fifo_din_o       = free_fifo_write_o ? DATA_W'(head[free_idx][ID_W +: PL_W]) : '0;

`ifdef FALAFEL_ARB_STATS_EN
  // A head belongs to one class, so a channel gains at most one grant per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_o <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((alloc_gnt[c] || free_gnt[c]) && (grant_cnt_o[c] != 32'hFFFF_FFFF))
          grant_cnt_o[c] <= grant_cnt_o[c] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_falafel_rr_input_arbiter.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_falafel_rr_input_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 8;
  localparam int CH_W   = 2;

  logic                          clk;
  logic                          rst_i;
  logic [NUM_CH-1:0]             req_val_i;
  logic [NUM_CH-1:0]             req_rdy_o;
  logic [NUM_CH-1:0][DATA_W-1:0] req_data_i;
  logic [NUM_CH-1:0][ID_W-1:0]   req_id_i;
  logic                          alloc_fifo_full_i;
  logic                          alloc_fifo_write_o;
  logic [DATA_W-1:0]             alloc_fifo_din_size_o;
  logic [ID_W-1:0]               alloc_fifo_din_id_o;
  logic                          free_fifo_full_i;
  logic                          free_fifo_write_o;
  logic [DATA_W-1:0]             free_fifo_din_o;
  logic                          illegal_o;
  logic [CH_W-1:0]               illegal_ch_o;

  logic [DATA_W+ID_W-1:0] alloc_exp_q[$];
  logic [DATA_W-1:0]      free_exp_q[$];
  logic [CH_W-1:0]        ill_exp_q[$];

  int checks;
  int failures;
  int alloc_wr_cnt;

  falafel_rr_input_arbiter dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .req_val_i             (req_val_i),
    .req_rdy_o             (req_rdy_o),
    .req_data_i            (req_data_i),
    .req_id_i              (req_id_i),
    .alloc_fifo_full_i     (alloc_fifo_full_i),
    .alloc_fifo_write_o    (alloc_fifo_write_o),
    .alloc_fifo_din_size_o (alloc_fifo_din_size_o),
    .alloc_fifo_din_id_o   (alloc_fifo_din_id_o),
    .free_fifo_full_i      (free_fifo_full_i),
    .free_fifo_write_o     (free_fifo_write_o),
    .free_fifo_din_o       (free_fifo_din_o),
    .illegal_o             (illegal_o),
    .illegal_ch_o          (illegal_ch_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W+ID_W-1:0] exp_alloc(input int pl, input int id);
    return {2'b00, 30'(pl), 8'(id)};
  endfunction

  // driver tasks
  task automatic clear_reqs();
    req_val_i  = '0;
    req_data_i = '0;
    req_id_i   = '0;
  endtask

  task automatic set_req(input int ch, input logic [1:0] op, input int pl, input int id);
    req_val_i[ch]  = 1'b1;
    req_data_i[ch] = {op, 30'(pl)};
    req_id_i[ch]   = 8'(id);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue();
    tick();
    clear_reqs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((alloc_exp_q.size() + free_exp_q.size() + ill_exp_q.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(alloc_exp_q.size() + free_exp_q.size() + ill_exp_q.size()), 64'd0);
    tick();
    tick();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_i) begin
      if (alloc_fifo_write_o) begin
        alloc_wr_cnt++;
        if (alloc_exp_q.size() == 0) chk("alloc_unexpected", 64'd1, 64'd0);
        else chk("alloc_word", {alloc_fifo_din_size_o, alloc_fifo_din_id_o}, alloc_exp_q.pop_front());
      end
      if (free_fifo_write_o) begin
        if (free_exp_q.size() == 0) chk("free_unexpected", 64'd1, 64'd0);
        else chk("free_word", 64'(free_fifo_din_o), 64'(free_exp_q.pop_front()));
      end
      if (illegal_o) begin
        if (ill_exp_q.size() == 0) chk("illegal_unexpected", 64'd1, 64'd0);
        else chk("illegal_ch", 64'(illegal_ch_o), 64'(ill_exp_q.pop_front()));
      end
    end
  end

  initial begin : main
    int idx[NUM_CH];
    logic [NUM_CH-1:0] acc;
    int guard;
    int wr_before;
    int bp_idx;

    checks = 0;
    failures = 0;
    alloc_wr_cnt = 0;
    rst_i = 1'b1;
    alloc_fifo_full_i = 1'b0;
    free_fifo_full_i = 1'b0;
    clear_reqs();

    // reset state
    #2;
    chk("rst_rdy", 64'(req_rdy_o), 64'd0);
    chk("rst_alloc_wr", 64'(alloc_fifo_write_o), 64'd0);
    chk("rst_free_wr", 64'(free_fifo_write_o), 64'd0);
    chk("rst_illegal", 64'(illegal_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 64'(req_rdy_o), 64'hF);

    // single alloc, one-cycle latency
    tick();
    set_req(0, 2'b00, 'h40, 3);
    alloc_exp_q.push_back(exp_alloc('h40, 3));
    issue();
    @(negedge clk);
    chk("single_latency", 64'(alloc_fifo_write_o), 64'd1);
    chk("single_rdy0", 64'(req_rdy_o[0]), 64'd1);
    drain();

    // fairness from a fresh pointer
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int n = 0; n < 12; n++)
      alloc_exp_q.push_back(exp_alloc('h100 + (n % 4) * 16 + n / 4, (n % 4) * 4 + n / 4));
    wr_before = alloc_wr_cnt;
    for (int c = 0; c < NUM_CH; c++) idx[c] = 0;
    guard = 0;
    while ((idx[0] < 3 || idx[1] < 3 || idx[2] < 3 || idx[3] < 3) && guard < 50) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (idx[c] < 3) set_req(c, 2'b00, 'h100 + c * 16 + idx[c], c * 4 + idx[c]);
        else req_val_i[c] = 1'b0;
      end
      @(negedge clk);
      acc = req_val_i & req_rdy_o;
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) if (acc[c]) idx[c]++;
      guard++;
    end
    clear_reqs();
    chk("fair_driver_done", 64'(guard < 50), 64'd1);
    drain();
    chk("fair_writes", 64'(alloc_wr_cnt - wr_before), 64'd12);

    // parallel classes; alloc_ptr -> 2, free_ptr -> 3
    set_req(1, 2'b00, 'h11, 'h21);
    set_req(2, 2'b01, 'h22, 0);
    alloc_exp_q.push_back(exp_alloc('h11, 'h21));
    free_exp_q.push_back(32'h22);
    issue();
    @(negedge clk);
    chk("par_alloc_wr", 64'(alloc_fifo_write_o), 64'd1);
    chk("par_free_wr", 64'(free_fifo_write_o), 64'd1);
    drain();
    // ptr at 2: ch3 beats ch1
    set_req(1, 2'b00, 'h31, 1);
    set_req(3, 2'b00, 'h33, 3);
    alloc_exp_q.push_back(exp_alloc('h33, 3));
    alloc_exp_q.push_back(exp_alloc('h31, 1));
    issue();
    drain();
    // ptr at 3: ch3 beats ch0
    set_req(0, 2'b01, 'h40, 0);
    set_req(3, 2'b01, 'h43, 0);
    free_exp_q.push_back(32'h43);
    free_exp_q.push_back(32'h40);
    issue();
    drain();

    // alloc backpressure
    alloc_fifo_full_i = 1'b1;
    bp_idx = 0;
    for (int k = 0; k < 5; k++) begin
      if (bp_idx < 3) set_req(0, 2'b00, 'h50 + bp_idx, 'h50 + bp_idx);
      else clear_reqs();
      @(negedge clk);
      chk("bp_no_write", 64'(alloc_fifo_write_o), 64'd0);
      acc = req_val_i & req_rdy_o;
      @(posedge clk);
      #1;
      if (acc[0]) bp_idx++;
    end
    clear_reqs();
    chk("bp_accepted", 64'(bp_idx), 64'd2);
    @(negedge clk);
    chk("bp_rdy_low", 64'(req_rdy_o[0]), 64'd0);
    alloc_exp_q.push_back(exp_alloc('h50, 'h50));
    alloc_exp_q.push_back(exp_alloc('h51, 'h51));
    alloc_fifo_full_i = 1'b0;
    drain();
    chk("bp_rdy_back", 64'(req_rdy_o[0]), 64'd1);

    // free backpressure; free_ptr -> 3
    free_fifo_full_i = 1'b1;
    set_req(2, 2'b01, 'h77, 0);
    issue();
    repeat (2) begin
      @(negedge clk);
      chk("fbp_no_write", 64'(free_fifo_write_o), 64'd0);
    end
    free_exp_q.push_back(32'h77);
    free_fifo_full_i = 1'b0;
    drain();

    // illegal opcode
    set_req(3, 2'b10, 'h99, 0);
    ill_exp_q.push_back(2'd3);
    issue();
    @(negedge clk);
    chk("ill_no_alloc", 64'(alloc_fifo_write_o), 64'd0);
    chk("ill_no_free", 64'(free_fifo_write_o), 64'd0);
    @(negedge clk);
    chk("ill_one_cycle", 64'(illegal_o), 64'd0);
    set_req(3, 2'b00, 'h5A, 'h5A);
    alloc_exp_q.push_back(exp_alloc('h5A, 'h5A));
    issue();
    drain();
    set_req(1, 2'b11, 'h1, 0);
    set_req(2, 2'b10, 'h2, 0);
    ill_exp_q.push_back(2'd1);
    ill_exp_q.push_back(2'd2);
    issue();
    drain();

    // async reset mid-operation; move alloc_ptr to 3 first
    set_req(2, 2'b00, 'h62, 2);
    alloc_exp_q.push_back(exp_alloc('h62, 2));
    issue();
    drain();
    alloc_fifo_full_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NUM_CH; c++) set_req(c, 2'b00, 'h70 + k, c);
      issue();
    end
    @(negedge clk);
    chk("ar_bufs_full", 64'(req_rdy_o), 64'd0);
    @(posedge clk);
    #1 alloc_fifo_full_i = 1'b0;
    #1 chk("ar_pre_write", 64'(alloc_fifo_write_o), 64'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("ar_write_cleared", 64'(alloc_fifo_write_o), 64'd0);
    chk("ar_size_cleared", 64'(alloc_fifo_din_size_o), 64'd0);
    chk("ar_rdy_low", 64'(req_rdy_o), 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("ar_rdy_empty", 64'(req_rdy_o), 64'hF);
    tick();
    tick();
    // pointers back at 0: ch0 wins over ch3 in both classes
    set_req(0, 2'b00, 'h80, 8);
    set_req(3, 2'b00, 'h83, 9);
    alloc_exp_q.push_back(exp_alloc('h80, 8));
    alloc_exp_q.push_back(exp_alloc('h83, 9));
    issue();
    drain();
    set_req(0, 2'b01, 'h90, 0);
    set_req(3, 2'b01, 'h93, 0);
    free_exp_q.push_back(32'h90);
    free_exp_q.push_back(32'h93);
    issue();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
